// File: rtl/fp_delta_coalesce.sv
// fp_delta_coalesce: merges consecutive bfloat16 deltas that target the same
// vertex into one output record, using an external combinational bf16 adder.
// One accumulator tracks the current burst. It is flushed when the burst ends
// (in_last), when the count reaches MAX_ACC, or when a delta for another vertex
// arrives.
module fp_delta_coalesce #(
  parameter int VID_W   = 8,
  parameter int MAX_ACC = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VID_W-1:0] in_vid,
  input  logic [15:0]      in_delta,
  input  logic             in_last,
  output logic [15:0]      add_opA,
  output logic [15:0]      add_opB,
  input  logic [15:0]      add_sum,
  input  logic             add_overflow,
  input  logic             add_inexact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VID_W-1:0] out_vid,
  output logic [15:0]      out_value,
  output logic [4:0]       out_count,
  output logic             out_overflow,
  output logic             out_inexact
);

  localparam logic [4:0] MAX_C = 5'(MAX_ACC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_r;
  logic [VID_W-1:0] acc_vid_r;
  logic [15:0]      acc_value_r;
  logic [4:0]       acc_count_r;
  logic             acc_ovf_r;
  logic             acc_inx_r;
  logic             out_valid_r;

  logic             ready_s;
  logic             vid_match_s;
  logic [4:0]       count_inc_s;
  logic             at_max_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             load_s;
  logic             merge_s;

  // Ready decode and handshake qualifiers; ready is forced low during reset.
  always_comb begin
    ready_s     = 1'b0;
    vid_match_s = (in_vid == acc_vid_r);
    count_inc_s = acc_count_r + 5'd1;
    at_max_s    = (count_inc_s == MAX_C);
    case (state_r)
      IDLE:    ready_s = 1'b1;
      ACCUM:   ready_s = vid_match_s;
      FLUSH:   ready_s = out_ready;
      default: ready_s = 1'b0;
    endcase
    if (reset) begin
      in_ready = 1'b0;
    end else begin
      in_ready = ready_s;
    end
    in_fire_s  = in_valid & in_ready;
    out_fire_s = out_valid_r & out_ready;
    // IDLE and FLUSH start a fresh burst; only ACCUM adds into the accumulator.
    load_s     = in_fire_s & ((state_r == IDLE) | (state_r == FLUSH));
    merge_s    = in_fire_s & (state_r == ACCUM);
  end

  // Burst control FSM; out_valid is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_fire_s) begin
            state_r     <= in_last ? FLUSH : ACCUM;
            out_valid_r <= in_last;
          end
        end
        ACCUM: begin
          if (in_valid && !vid_match_s) begin
            // Different vertex: close this burst, leave the delta waiting.
            state_r     <= FLUSH;
            out_valid_r <= 1'b1;
          end else if (merge_s && (in_last || at_max_s)) begin
            state_r     <= FLUSH;
            out_valid_r <= 1'b1;
          end
        end
        FLUSH: begin
          if (out_fire_s) begin
            if (in_fire_s) begin
              state_r     <= in_last ? FLUSH : ACCUM;
              out_valid_r <= in_last;
            end else begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator datapath: load on burst start, add on merge, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_vid_r   <= '0;
      acc_value_r <= 16'h0000;
      acc_count_r <= 5'd0;
      acc_ovf_r   <= 1'b0;
      acc_inx_r   <= 1'b0;
    end else if (load_s) begin
      acc_vid_r   <= in_vid;
      acc_value_r <= in_delta;
      acc_count_r <= 5'd1;
      acc_ovf_r   <= 1'b0;
      acc_inx_r   <= 1'b0;
    end else if (merge_s) begin
      acc_value_r <= add_sum;
      acc_count_r <= count_inc_s;
      acc_ovf_r   <= acc_ovf_r | add_overflow;
      acc_inx_r   <= acc_inx_r | add_inexact;
    end else begin
      acc_vid_r   <= acc_vid_r;
      acc_value_r <= acc_value_r;
      acc_count_r <= acc_count_r;
      acc_ovf_r   <= acc_ovf_r;
      acc_inx_r   <= acc_inx_r;
    end
  end

  assign add_opA      = acc_value_r;
  assign add_opB      = in_delta;
  assign out_valid    = out_valid_r;
  assign out_vid      = acc_vid_r;
  assign out_value    = acc_value_r;
  assign out_count    = acc_count_r;
  assign out_overflow = acc_ovf_r;
  assign out_inexact  = acc_inx_r;

endmodule

// File: tb/tb_fp_delta_coalesce.sv
// Testbench for fp_delta_coalesce: directed bursts with hand-computed results,
// scoreboard queue filled by stimulus and drained by an output monitor.
module tb_fp_delta_coalesce;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_vid;
  logic [15:0] in_delta;
  logic        in_last;
  logic [15:0] add_opA;
  logic [15:0] add_opB;
  logic [15:0] add_sum;
  logic        add_overflow;
  logic        add_inexact;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_vid;
  logic [15:0] out_value;
  logic [4:0]  out_count;
  logic        out_overflow;
  logic        out_inexact;

  logic        force_ovf;
  logic [16:0] add_res;

  typedef struct packed {
    logic [7:0]  vid;
    logic [15:0] value;
    logic [4:0]  count;
    logic        ovf;
    logic        inx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  fp_delta_coalesce #(.VID_W(8), .MAX_ACC(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_vid(in_vid),
    .in_delta(in_delta), .in_last(in_last),
    .add_opA(add_opA), .add_opB(add_opB), .add_sum(add_sum),
    .add_overflow(add_overflow), .add_inexact(add_inexact),
    .out_valid(out_valid), .out_ready(out_ready), .out_vid(out_vid),
    .out_value(out_value), .out_count(out_count),
    .out_overflow(out_overflow), .out_inexact(out_inexact)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment adder: positive normal bf16 operands, truncating, flags inexact.
  function automatic logic [16:0] bf_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    logic [7:0]  ex, d;
    logic [23:0] mx, my;
    logic [24:0] s;
    logic        lost;
    if (a[14:0] == 15'd0) return {1'b0, b};
    if (b[14:0] == 15'd0) return {1'b0, a};
    x = a; y = b;
    if (y[14:7] > x[14:7]) begin t = x; x = y; y = t; end
    ex = x[14:7];
    d  = x[14:7] - y[14:7];
    mx = {1'b1, x[6:0], 16'h0000};
    my = (d > 8'd16) ? 24'h000000 : ({1'b1, y[6:0], 16'h0000} >> d);
    s  = {1'b0, mx} + {1'b0, my};
    lost = 1'b0;
    if (s[24]) begin
      lost = s[0];
      s    = s >> 1;
      ex   = ex + 8'd1;
    end
    lost = lost | (s[15:0] != 16'h0000);
    return {lost, 1'b0, ex, s[22:16]};
  endfunction

  assign add_res      = bf_add(add_opA, add_opB);
  assign add_sum      = add_res[15:0];
  assign add_inexact  = add_res[16];
  assign add_overflow = force_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted output against the scoreboard head.
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {24'h0, out_vid}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_vid",      {24'h0, out_vid},      {24'h0, e.vid});
        check("out_value",    {16'h0, out_value},    {16'h0, e.value});
        check("out_count",    {27'h0, out_count},    {27'h0, e.count});
        check("out_overflow", {31'h0, out_overflow}, {31'h0, e.ovf});
        check("out_inexact",  {31'h0, out_inexact},  {31'h0, e.inx});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input logic [7:0] v, input logic [15:0] val,
                            input logic [4:0] c, input logic o, input logic i);
    exp_t e;
    e.vid = v; e.value = val; e.count = c; e.ovf = o; e.inx = i;
    exp_q.push_back(e);
  endtask

  // Present one delta (called just after a rising edge) and wait until accepted.
  task automatic send(input logic [7:0] v, input logic [15:0] d, input logic l,
                      output int stalls);
    int n;
    in_valid = 1'b1; in_vid = v; in_delta = d; in_last = l;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    stalls = n;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int st;
    int sum_st;
    int n;
    reset = 1'b1; in_valid = 1'b0; in_vid = 8'h00; in_delta = 16'h0000;
    in_last = 1'b0; out_ready = 1'b1; force_ovf = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_in_ready",  {31'h0, in_ready},  32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_vid",   {24'h0, out_vid},   32'd0);
    check("rst_out_value", {16'h0, out_value}, 32'd0);
    check("rst_out_count", {27'h0, out_count}, 32'd0);
    check("rst_flags",     {30'h0, out_overflow, out_inexact}, 32'd0);
    step(); step();
    reset = 1'b0;
    @(negedge clock);
    check("idle_in_ready", {31'h0, in_ready}, 32'd1);
    step();

    // Two 1.0 deltas to vid 5 -> 2.0, count 2, visible right after the closing accept
    expect_out(8'd5, 16'h4000, 5'd2, 1'b0, 1'b0);
    send(8'd5, 16'h3F80, 1'b0, st);
    send(8'd5, 16'h3F80, 1'b1, st);
    @(negedge clock);
    check("latency_out_valid", {31'h0, out_valid}, 32'd1);
    step();

    // vid 3 burst closed by a vid 4 delta that stalls exactly one cycle
    expect_out(8'd3, 16'h4040, 5'd2, 1'b0, 1'b0);
    expect_out(8'd4, 16'h3F80, 5'd1, 1'b0, 1'b0);
    send(8'd3, 16'h4000, 1'b0, st);
    send(8'd3, 16'h3F80, 1'b0, st);
    send(8'd4, 16'h3F80, 1'b1, st);
    check("vid_change_stall", st, 32'd1);

    // 20 deltas to vid 1: split at MAX_ACC=16, then a 4-delta burst
    expect_out(8'd1, 16'h4180, 5'd16, 1'b0, 1'b0);
    expect_out(8'd1, 16'h4080, 5'd4, 1'b0, 1'b0);
    sum_st = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'd1, 16'h3F80, (i == 19), st);
      sum_st += st;
    end
    check("max_acc_no_stall", sum_st, 32'd0);

    // Output back-pressure for 5 cycles with a waiting vid 8 delta
    expect_out(8'd7, 16'h4000, 5'd2, 1'b0, 1'b0);
    expect_out(8'd8, 16'h3F80, 5'd1, 1'b0, 1'b0);
    send(8'd7, 16'h3F80, 1'b0, st);
    out_ready = 1'b0;
    send(8'd7, 16'h3F80, 1'b1, st);
    in_valid = 1'b1; in_vid = 8'd8; in_delta = 16'h3F80; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_in_ready",  {31'h0, in_ready},  32'd0);
      check("bp_out_valid", {31'h0, out_valid}, 32'd1);
      check("bp_out_value", {16'h0, out_value}, 32'h4000);
      check("bp_out_vid",   {24'h0, out_vid},   32'd7);
      check("bp_out_count", {27'h0, out_count}, 32'd2);
    end
    step();
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_resume_ready", {31'h0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;

    // Reset mid-burst discards 3 accumulated deltas
    send(8'd2, 16'h3F80, 1'b0, st);
    send(8'd2, 16'h3F80, 1'b0, st);
    send(8'd2, 16'h3F80, 1'b0, st);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_in_ready", {31'h0, in_ready}, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    check("midrst_out_count", {27'h0, out_count}, 32'd0);
    step();
    expect_out(8'd2, 16'h3F80, 5'd1, 1'b0, 1'b0);
    send(8'd2, 16'h3F80, 1'b1, st);

    // Overflow on one merge is sticky for that burst only; same vid next burst
    expect_out(8'd6, 16'h4040, 5'd3, 1'b1, 1'b0);
    expect_out(8'd6, 16'h4000, 5'd2, 1'b0, 1'b0);
    send(8'd6, 16'h3F80, 1'b0, st);
    force_ovf = 1'b1;
    send(8'd6, 16'h3F80, 1'b0, st);
    force_ovf = 1'b0;
    send(8'd6, 16'h3F80, 1'b1, st);
    send(8'd6, 16'h3F80, 1'b0, st);
    send(8'd6, 16'h3F80, 1'b1, st);

    // Inexact merge: 1.0 + 2^-8 truncates back to 1.0
    expect_out(8'd9, 16'h3F80, 5'd2, 1'b0, 1'b1);
    send(8'd9, 16'h3F80, 1'b0, st);
    send(8'd9, 16'h3B80, 1'b1, st);

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
